// File: rtl/lwlw_monitor_pkg.sv
// Shared types and widths for the trace-symbol monitor controller and its FIFO.
package lwlw_monitor_pkg;

    localparam int SYM_W = 8;
    localparam int REP_W = 16;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } mon_state_e;

endpackage

// File: rtl/lwlw_symbol_fifo.sv
// Synchronous symbol FIFO with registered read port; the read register holds
// the last popped symbol, so it doubles as the automata symbol output.
module lwlw_symbol_fifo
    import lwlw_monitor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             i_srst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [SYM_W-1:0] i_wdata,
    input  logic             i_pop,
    output logic [SYM_W-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SYM_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [SYM_W-1:0] r_rdata;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_pop_ok  = i_pop && !o_empty && !i_clr;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok) && !i_clr;
    assign o_rdata   = r_rdata;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_rdata <= '0;
        end else if (w_pop_ok) begin
            r_rdata <= r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/lwlw_monitor_ctrl.sv
// Trace-symbol monitor controller: arbitrates two commit ports into a FIFO,
// feeds the automata one symbol per cycle and latches the first violation.
module lwlw_monitor_ctrl
    import lwlw_monitor_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SEQ_W      = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [SYM_W-1:0] req0_symbol,
    input  logic             req1_valid,
    input  logic [SYM_W-1:0] req1_symbol,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic             flush,
    output logic [SYM_W-1:0] mon_symbols,
    output logic             mon_run,
    output logic             mon_reset,
    input  logic [REP_W-1:0] mon_reports,
    output logic             viol_valid,
    output logic [REP_W-1:0] viol_vector,
    output logic [SEQ_W-1:0] viol_seq,
    input  logic             viol_ack,
    output logic             busy
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    mon_state_e       r_state;
    logic [CNT_W-1:0] r_rst_cnt;
    logic             r_mon_run;
    logic             r_mon_reset;
    logic [SEQ_W-1:0] r_seq;
    logic [SEQ_W-1:0] r_run_seq;
    logic             r_pend;
    logic [SEQ_W-1:0] r_pend_seq;
    logic             r_viol_valid;
    logic [REP_W-1:0] r_viol_vector;
    logic [SEQ_W-1:0] r_viol_seq;
    logic             r_last_gnt1;

    logic             w_full;
    logic             w_empty;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_can_push;
    logic             w_push;
    logic [SYM_W-1:0] w_push_data;
    logic             w_viol_hit;
    logic             w_pop;

    // r_last_gnt1 starts at 1 so req0 wins the first contested cycle.
    assign w_grant0    = req0_valid && (!req1_valid || r_last_gnt1);
    assign w_grant1    = req1_valid && (!req0_valid || !r_last_gnt1);
    assign w_viol_hit  = (r_state == ST_RUN) && r_pend && (mon_reports != '0);
    assign w_pop       = (r_state == ST_RUN) && !w_empty && !flush && !w_viol_hit;
    assign w_can_push  = (r_state != ST_INIT) && !flush && (!w_full || w_pop);
    assign req0_ready  = w_grant0 && w_can_push;
    assign req1_ready  = w_grant1 && w_can_push;
    assign w_push      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign w_push_data = w_grant1 ? req1_symbol : req0_symbol;

    assign mon_run     = r_mon_run;
    assign mon_reset   = r_mon_reset;
    assign viol_valid  = r_viol_valid;
    assign viol_vector = r_viol_vector;
    assign viol_seq    = r_viol_seq;
    assign busy        = !w_empty || (r_state != ST_RUN);

    lwlw_symbol_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_srst  (reset),
        .i_clr   (flush),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (mon_symbols),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_INIT;
            r_rst_cnt     <= '0;
            r_mon_run     <= 1'b0;
            r_mon_reset   <= 1'b1;
            r_seq         <= '0;
            r_run_seq     <= '0;
            r_pend        <= 1'b0;
            r_pend_seq    <= '0;
            r_viol_valid  <= 1'b0;
            r_viol_vector <= '0;
            r_viol_seq    <= '0;
            r_last_gnt1   <= 1'b1;
        end else begin
            r_mon_run  <= w_pop;
            // Reports describe the symbol shown one cycle earlier; carry its sequence along.
            r_pend     <= r_mon_run && !flush;
            r_pend_seq <= r_run_seq;
            if (w_pop) begin
                r_run_seq <= r_seq;
                r_seq     <= r_seq + 1'b1;
            end
            if (w_push) begin
                r_last_gnt1 <= w_grant1;
            end
            if (flush) begin
                r_state      <= ST_INIT;
                r_rst_cnt    <= '0;
                r_mon_reset  <= 1'b1;
                r_seq        <= '0;
                r_viol_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_INIT: begin
                        if (r_rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
                            r_state     <= ST_RUN;
                            r_mon_reset <= 1'b0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_viol_hit) begin
                            r_state       <= ST_HOLD;
                            r_viol_valid  <= 1'b1;
                            r_viol_vector <= mon_reports;
                            r_viol_seq    <= r_pend_seq;
                        end
                    end
                    ST_HOLD: begin
                        if (viol_ack) begin
                            r_state      <= ST_INIT;
                            r_rst_cnt    <= '0;
                            r_mon_reset  <= 1'b1;
                            r_viol_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_INIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lwlw_monitor_ctrl.sv
// Bench for lwlw_monitor_ctrl: scenario tasks against a queue-based FIFO model
// and a scripted automata that reports on a chosen symbol index.
module tb_lwlw_monitor_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_symbol, req1_symbol;
    logic        req0_ready, req1_ready;
    logic        flush;
    logic [7:0]  mon_symbols;
    logic        mon_run, mon_reset;
    logic [15:0] mon_reports = 16'h0;
    logic        viol_valid;
    logic [15:0] viol_vector;
    logic [15:0] viol_seq;
    logic        viol_ack;
    logic        busy;

    logic        w_req0_ready, w_req1_ready, w_mon_run, w_mon_reset, w_viol_valid, w_busy;
    logic [7:0]  w_mon_symbols;
    logic [15:0] w_viol_vector;
    logic [3:0]  w_viol_seq;

    always #5 clk = ~clk;

    lwlw_monitor_ctrl dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_symbol(req0_symbol),
        .req1_valid(req1_valid), .req1_symbol(req1_symbol),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .flush(flush), .mon_symbols(mon_symbols), .mon_run(mon_run),
        .mon_reset(mon_reset), .mon_reports(mon_reports),
        .viol_valid(viol_valid), .viol_vector(viol_vector), .viol_seq(viol_seq),
        .viol_ack(viol_ack), .busy(busy)
    );

    // Narrow sequence counter copy, fed identically, to observe wrap-around.
    lwlw_monitor_ctrl #(.SEQ_W(4)) dut_w (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_symbol(req0_symbol),
        .req1_valid(req1_valid), .req1_symbol(req1_symbol),
        .req0_ready(w_req0_ready), .req1_ready(w_req1_ready),
        .flush(flush), .mon_symbols(w_mon_symbols), .mon_run(w_mon_run),
        .mon_reset(w_mon_reset), .mon_reports(mon_reports),
        .viol_valid(w_viol_valid), .viol_vector(w_viol_vector), .viol_seq(w_viol_seq),
        .viol_ack(viol_ack), .busy(w_busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  acc_q[$];
    logic [7:0]  iss_q[$];
    int          iss_cnt = 0;
    int          viol_at = -1;
    logic [15:0] viol_vec = 16'h0;
    logic [15:0] rep_next = 16'h0;

    // Passive monitor: accepted symbols, issued symbols, scripted automata report.
    always @(negedge clk) begin
        rep_next = 16'h0;
        if (!reset) begin
            if (req0_valid && req0_ready) acc_q.push_back(req0_symbol);
            if (req1_valid && req1_ready) acc_q.push_back(req1_symbol);
            if (mon_run) begin
                iss_q.push_back(mon_symbols);
                if (iss_cnt == viol_at) rep_next = viol_vec;
                iss_cnt++;
            end
        end
    end

    always @(posedge clk) mon_reports <= rep_next;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_diff();
        if (iss_q.size() != acc_q.size()) return -2;
        foreach (acc_q[k]) if (iss_q[k] !== acc_q[k]) return k;
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; viol_ack = 1'b0;
        req0_symbol = 8'h0; req1_symbol = 8'h0; viol_at = -1;
        repeat (3) @(posedge clk);
        #1;
        acc_q.delete(); iss_q.delete(); iss_cnt = 0;
        reset = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic wait_viol(input string tag);
        int n = 0;
        while (viol_valid !== 1'b1 && n < 60) begin cycle(); n++; end
        checks++;
        if (viol_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: viol_valid=%b after %0d cycles, required 1", tag, viol_valid, n);
        end
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_symbol = 8'h5A; req1_symbol = 8'hA5;
        flush = 1'b0; viol_ack = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mon_run, mon_reset, viol_valid, req0_ready, req1_ready, busy} !== 6'b010001) begin
            errors++;
            $display("FAIL reset_flags: run/rst/viol/rdy0/rdy1/busy=%b required 010001",
                     {mon_run, mon_reset, viol_valid, req0_ready, req1_ready, busy});
        end
        checks++;
        if ({mon_symbols, viol_vector, viol_seq} !== 40'h0) begin
            errors++;
            $display("FAIL reset_data: sym=%h vec=%h seq=%h required 0", mon_symbols, viol_vector, viol_seq);
        end
        @(posedge clk); #1;
        acc_q.delete(); iss_q.delete(); iss_cnt = 0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({mon_reset, req0_ready, req1_ready} !== {(c < 2), (c == 2), 1'b0}) begin
                errors++;
                $display("FAIL init_cycle%0d: mon_reset/rdy0/rdy1=%b required %b", c,
                         {mon_reset, req0_ready, req1_ready}, {(c < 2), (c == 2), 1'b0});
            end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_arbitration();
        int bad = 0;
        do_reset();
        req0_symbol = 8'h11; req1_symbol = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (mon_run !== 1'b1) begin
                    errors++;
                    $display("FAIL arb_run_cycle%0d: mon_run=%b required 1", i, mon_run);
                end
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (8) cycle();
        checks++;
        if (acc_q.size() != 12) begin
            errors++;
            $display("FAIL arb_count: accepted %0d required 12", acc_q.size());
        end
        foreach (acc_q[k]) if (acc_q[k] !== ((k % 2 == 0) ? 8'h11 : 8'h22)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL arb_order: %0d out-of-order acceptances, required 0", bad);
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL arb_fifo_order: first difference at %0d, required -1", first_diff());
        end
        $display("test_arbitration done: %0d accepted, %0d issued", acc_q.size(), iss_q.size());
    endtask

    task automatic test_full_hold();
        int n = 0;
        int runs = 0;
        do_reset();
        viol_at = 0; viol_vec = 16'h0001;
        req0_valid = 1'b1; req0_symbol = 8'hA0;
        cycle();
        req0_valid = 1'b0;
        wait_viol("hold");
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req1_symbol = 8'hB0 + 8'(k);
            @(negedge clk);
            checks++;
            if ({req1_ready, mon_run} !== {(k < 4), 1'b0}) begin
                errors++;
                $display("FAIL hold_fill%0d: ready/run=%b required %b", k, {req1_ready, mon_run}, {(k < 4), 1'b0});
            end
            @(posedge clk); #1;
        end
        viol_ack = 1'b1;
        cycle();
        viol_ack = 1'b0;
        while (mon_reset !== 1'b0 && n < 10) begin cycle(); n++; end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (req1_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_pushpop%0d: req1_ready=%b required 1", k, req1_ready);
            end
            @(posedge clk); #1;
            req1_symbol = 8'hC0 + 8'(k);
        end
        req1_valid = 1'b0;
        @(negedge clk);
        repeat (10) begin
            @(negedge clk);
            if (mon_run === 1'b1) runs++;
        end
        checks++;
        if (runs != 4) begin
            errors++;
            $display("FAIL full_occupancy: drained %0d symbols, required 4", runs);
        end
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL hold_fifo_order: first difference at %0d, required -1", first_diff());
        end
        $display("test_full_hold done: %0d accepted, %0d issued", acc_q.size(), iss_q.size());
    endtask

    task automatic test_violation();
        do_reset();
        viol_at = 2; viol_vec = 16'h0040;
        req0_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req0_symbol = 8'h30 + 8'(k);
            cycle();
        end
        req0_valid = 1'b0;
        wait_viol("viol");
        checks++;
        if (viol_vector !== viol_vec || viol_seq !== 16'(viol_at)) begin
            errors++;
            $display("FAIL viol_latch: vec=%h seq=%0d required vec=%h seq=%0d", viol_vector, viol_seq, viol_vec, viol_at);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({mon_run, viol_valid} !== 2'b01) begin
                errors++;
                $display("FAIL viol_hold%0d: run/valid=%b required 01", k, {mon_run, viol_valid});
            end
        end
        @(posedge clk); #1;
        viol_ack = 1'b1;
        cycle();
        viol_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({mon_reset, viol_valid} !== {(c < 2), 1'b0}) begin
                errors++;
                $display("FAIL ack_init%0d: mon_reset/valid=%b required %b", c, {mon_reset, viol_valid}, {(c < 2), 1'b0});
            end
            cycle();
        end
        repeat (15) cycle();
        checks++;
        if (first_diff() != -1 || acc_q.size() != 6) begin
            errors++;
            $display("FAIL viol_fifo_order: diff=%0d accepted=%0d required -1 and 6", first_diff(), acc_q.size());
        end
        $display("test_violation done: vec=%h seq=%0d", viol_vector, viol_seq);
    endtask

    task automatic test_flush_ack();
        do_reset();
        viol_at = 0; viol_vec = 16'h0100;
        req0_valid = 1'b1; req0_symbol = 8'hC0;
        cycle();
        req0_valid = 1'b0;
        wait_viol("flush_pre");
        req0_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            req0_symbol = 8'hC0 + 8'(k);
            cycle();
        end
        flush = 1'b1; viol_ack = 1'b1; req0_symbol = 8'hCF;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: req0_ready=%b required 0", req0_ready);
        end
        @(posedge clk); #1;
        flush = 1'b0; viol_ack = 1'b0; req0_valid = 1'b0;
        checks++;
        if ({viol_valid, mon_reset, busy, mon_run} !== 4'b0110) begin
            errors++;
            $display("FAIL flush_state: valid/rst/busy/run=%b required 0110", {viol_valid, mon_reset, busy, mon_run});
        end
        repeat (2) cycle();
        checks++;
        if ({busy, mon_reset} !== 2'b00) begin
            errors++;
            $display("FAIL flush_empty: busy/mon_reset=%b required 00", {busy, mon_reset});
        end
        repeat (5) cycle();
        checks++;
        if (iss_q.size() != 1 || acc_q.size() != 4) begin
            errors++;
            $display("FAIL flush_drop: issued=%0d accepted=%0d required 1 and 4", iss_q.size(), acc_q.size());
        end
        viol_at = iss_cnt; viol_vec = 16'h0200;
        req0_valid = 1'b1; req0_symbol = 8'hD0;
        cycle();
        req0_valid = 1'b0;
        wait_viol("flush_post");
        checks++;
        if (viol_seq !== 16'h0 || viol_vector !== 16'h0200) begin
            errors++;
            $display("FAIL flush_seq: seq=%0d vec=%h required 0 and 0200", viol_seq, viol_vector);
        end
        $display("test_flush_ack done");
    endtask

    task automatic test_seq_wrap();
        int n = 0;
        do_reset();
        viol_at = 16; viol_vec = 16'h8001;
        while (acc_q.size() < 17 && n < 300) begin
            req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
            req0_symbol = 8'($urandom); req1_symbol = 8'($urandom);
            cycle(); n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_viol("wrap");
        checks++;
        if (viol_seq !== 16'(viol_at % 65536) || w_viol_seq !== 4'(viol_at % 16)) begin
            errors++;
            $display("FAIL seq_wrap: seq16=%0d seq4=%0d required %0d and %0d", viol_seq, w_viol_seq,
                     viol_at % 65536, viol_at % 16);
        end
        $display("test_seq_wrap done: seq16=%0d seq4=%0d", viol_seq, w_viol_seq);
    endtask

    task automatic test_random();
        int last = 1;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            req0_valid = ($urandom_range(0, 9) < 7); req1_valid = ($urandom_range(0, 9) < 7);
            req0_symbol = 8'($urandom); req1_symbol = 8'($urandom);
            @(negedge clk);
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL rand_grant%0d: both readies high, required at most one", i);
            end
            if (req0_valid && req1_valid && (req0_ready || req1_ready)) begin
                checks++;
                if (req1_ready !== (last == 0)) begin
                    errors++;
                    $display("FAIL rand_rr%0d: req1_ready=%b required %b", i, req1_ready, (last == 0));
                end
            end
            if (req0_valid && req0_ready) last = 0;
            if (req1_valid && req1_ready) last = 1;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (10) cycle();
        checks++;
        if (first_diff() != -1) begin
            errors++;
            $display("FAIL rand_fifo_order: first difference at %0d, required -1", first_diff());
        end
        $display("test_random done: %0d accepted, %0d issued", acc_q.size(), iss_q.size());
    endtask

    task automatic test_midreset();
        int n = 0;
        do_reset();
        viol_at = 0; viol_vec = 16'h0001;
        req0_valid = 1'b1; req0_symbol = 8'hE0;
        cycle();
        req0_valid = 1'b0;
        while (mon_run !== 1'b1 && n < 10) begin cycle(); n++; end
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if ({viol_valid, mon_run, mon_reset, busy} !== 4'b0011) begin
            errors++;
            $display("FAIL midreset: valid/run/rst/busy=%b required 0011", {viol_valid, mon_run, mon_reset, busy});
        end
        repeat (6) cycle();
        checks++;
        if (viol_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_report: viol_valid=%b required 0", viol_valid);
        end
        $display("test_midreset done");
    endtask

    initial begin
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; viol_ack = 1'b0;
        req0_symbol = 8'h0; req1_symbol = 8'h0;
        test_reset();
        test_arbitration();
        test_full_hold();
        test_violation();
        test_flush_ack();
        test_seq_wrap();
        test_random();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
